// File: rtl/prime_sieve_stream.sv
// Sieve of Eratosthenes over 0..lim held in a 1-bit-per-entry memory.
// When the sieve finishes, each prime is streamed in ascending order over a valid/ready port.
module prime_sieve_stream #(
  parameter int LIMIT = 999999,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] limit,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          prime_valid,
  output logic [AW-1:0] prime_data,
  output logic [AW-1:0] prime_count
);

  // Handshake: a beat transfers on a rising edge where prime_valid and out_ready are both high.
  // Once prime_valid is raised, it and prime_data hold until that edge. Only rst can drop them earlier.
  typedef enum logic [3:0] {
    IDLE, CLEAR, RD_I, CHK_I, MARK, RD_K, CHK_K, EMIT, DONE
  } state_t;

  localparam logic [AW-1:0] LIM_MAX = AW'(LIMIT);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   ONE_K   = (AW+1)'(1);

  state_t state, state_next;

  logic [AW-1:0]   lim, addr, i;
  logic [AW:0]     j, k;
  logic [2*AW-1:0] sq;
  logic            sq_gt, j_gt, k_gt;
  logic            flag;

  logic            mem [0:LIMIT];
  logic            mem_we, mem_wdata, mem_re;
  logic [AW-1:0]   mem_addr;

  // i*i is compared at full width, so i near 2^AW cannot wrap.
  assign sq    = {{AW{1'b0}}, i} * {{AW{1'b0}}, i};
  assign sq_gt = sq > {{AW{1'b0}}, lim};
  assign j_gt  = j > {1'b0, lim};
  assign k_gt  = k > {1'b0, lim};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = CLEAR;
      CLEAR:      if (addr == lim) state_next = RD_I;
      RD_I:       state_next = sq_gt ? RD_K : CHK_I;
      CHK_I:      state_next = flag ? RD_I : MARK;
      MARK:       if (j_gt) state_next = RD_I;
      RD_K:       state_next = k_gt ? DONE : CHK_K;
      CHK_K:      state_next = flag ? RD_K : EMIT;
      EMIT:       if (out_ready) state_next = RD_K;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE) && (state != DONE);
    done        = (state == DONE);
    prime_valid = (state == EMIT);
    mem_we      = (state == CLEAR) || ((state == MARK) && !j_gt);
    mem_wdata   = (state == MARK);
    mem_re      = (state == RD_I && !sq_gt) || (state == RD_K && !k_gt);
    mem_addr    = k[AW-1:0];
    case (state)
      CLEAR:   mem_addr = addr;
      RD_I:    mem_addr = i;
      MARK:    mem_addr = j[AW-1:0];
      default: mem_addr = k[AW-1:0];
    endcase
  end

  // Single-port memory with a 1-cycle read. Flag 1 marks a composite.
  always_ff @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_wdata;
    else if (mem_re) flag <= mem[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lim         <= '0;
      addr        <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      prime_data  <= '0;
      prime_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          lim         <= (limit > LIM_MAX) ? LIM_MAX : limit;
          addr        <= '0;
          prime_count <= '0;
        end
        CLEAR: begin
          addr <= addr + ONE_A;
          if (addr == lim) i <= AW'(2);
        end
        RD_I:  if (sq_gt) k <= (AW+1)'(2);
        CHK_I: begin
          if (flag) i <= i + ONE_A;
          else      j <= sq[AW:0];
        end
        MARK: begin
          if (!j_gt) j <= j + {1'b0, i};
          else       i <= i + ONE_A;
        end
        CHK_K: begin
          if (flag) k <= k + ONE_K;
          else      prime_data <= k[AW-1:0];
        end
        EMIT: if (out_ready) begin
          prime_count <= prime_count + ONE_A;
          k           <= k + ONE_K;
        end
        default: ;
      endcase
    end
  end

endmodule
